// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Writer side of the FIR weight interface. Coefficients arrive one per
//   accepted valid/ready beat and are staged in a shadow bank; once a full
//   set of NUM_TAPS coefficients has been received, a single COMMIT cycle
//   copies the shadow bank into the active bank that drives every tap.
//   The FIR datapath therefore only ever sees complete coefficient sets.
//
//   Optional feature (macro FIR_COEFF_READBACK_EN):
//     adds iv_rd_idx / ov_rd_data, a registered read port on the active bank.
//
//   Handshake: a coefficient is transferred on a rising edge where
//   i_coeff_valid && o_coeff_ready. o_coeff_ready is high only in LOAD and
//   does not depend on i_coeff_valid. The source may hold valid low for any
//   number of cycles. iv_coeff is ignored on every edge without a transfer.
//   i_abort in LOAD wins over a simultaneous transfer.
module fir_coeff_loader #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_TAPS   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [DATA_WIDTH-1:0]          iv_coeff,
  input  logic                           i_coeff_valid,
  output logic                           o_coeff_ready,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error,
`ifdef FIR_COEFF_READBACK_EN
  input  logic [$clog2(NUM_TAPS)-1:0]    iv_rd_idx,
  output logic [DATA_WIDTH-1:0]          ov_rd_data,
`endif
  // Debug view of the FSM state: 0 = IDLE, 1 = LOAD, 2 = COMMIT.
  output logic [1:0]                     o_state
);

  localparam int CNT_W = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        counter;
  logic [DATA_WIDTH-1:0]   shadow [NUM_TAPS];
  logic [DATA_WIDTH-1:0]   active [NUM_TAPS];

  // Status outputs are direct decodes of the registered state.
  assign o_coeff_ready = (state == LOAD);
  assign o_busy        = (state != IDLE);
  assign o_state       = state;

  // Flatten the active bank; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
    assign ov_weights[k*DATA_WIDTH +: DATA_WIDTH] = active[k];
  end

  // Load FSM: staging into the shadow bank and the atomic commit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      counter <= '0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= LOAD;
            counter <= '0;
            o_error <= 1'b0;
          end
        end
        LOAD: begin
          if (i_abort) begin
            // The coefficient offered on this edge is discarded.
            state   <= IDLE;
            o_error <= 1'b1;
          end else if (i_coeff_valid) begin
            shadow[counter] <= iv_coeff;
            counter         <= counter + 1'b1;
            if (counter == LAST_IDX) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          // Commit always completes; abort and start are not looked at here.
          for (int k = 0; k < NUM_TAPS; k++) begin
            active[k] <= shadow[k];
          end
          o_done <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  // Registered read port on the active bank; out-of-range index reads 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_rd_data <= '0;
    end else if (int'(iv_rd_idx) < NUM_TAPS) begin
      ov_rd_data <= active[iv_rd_idx];
    end else begin
      ov_rd_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
//   Directed bench for fir_coeff_loader with a tap-order scoreboard.
//   With FIR_COEFF_READBACK_EN defined, the read port is also exercised.
module tb_fir_coeff_loader;

  localparam int DW = 24;
  localparam int NT = 8;
  localparam int WW = NT * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [DW-1:0]   coeff = '0;
  logic            coeff_valid = 1'b0;
  logic            coeff_ready;
  logic [WW-1:0]   weights;
  logic            busy;
  logic            done;
  logic            error;
  logic [1:0]      state;
`ifdef FIR_COEFF_READBACK_EN
  logic [$clog2(NT)-1:0] rd_idx = '0;
  logic [DW-1:0]         rd_data;
`endif

  fir_coeff_loader #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .iv_coeff      (coeff),
    .i_coeff_valid (coeff_valid),
    .o_coeff_ready (coeff_ready),
    .ov_weights    (weights),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
`ifdef FIR_COEFF_READBACK_EN
    .iv_rd_idx     (rd_idx),
    .ov_rd_data    (rd_data),
`endif
    .o_state       (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] vec [NT];
  logic [WW-1:0] last_bank = '0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare the active bank tap by tap against the expected queue.
  task automatic check_bank(input string tag);
    logic [WW-1:0] e;
    e = '0;
    for (int k = 0; k < NT; k++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_q_empty"}, 1, 0);
        break;
      end
      e[k*DW +: DW] = exp_q.pop_front();
    end
    check(tag, weights, e);
    last_bank = e;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full load of vec[]. mode 0: valid held high; mode 1: valid only on odd
  // cycles. glitch pulses start during LOAD (cycle 3) and COMMIT (cycle NT+1)
  // of a mode-0 load. Returns in the cycle where o_done is seen.
  task automatic load(input int mode, input bit glitch, input string tag,
                      output int done_cyc, output int n_acc);
    int cyc;
    int idx;
    bit exp_rdy;
    for (int k = 0; k < NT; k++) exp_q.push_back(vec[k]);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    idx = 0;
    n_acc = 0;
    while (!done && cyc < 100) begin
      coeff_valid = (idx < NT) && (mode == 0 || (cyc % 2) == 1);
      coeff = coeff_valid ? vec[idx] : DW'($urandom);
      start = glitch && (cyc == 3 || cyc == NT + 1);
      exp_rdy = (mode == 0) ? (cyc <= NT) : (cyc <= 2 * NT - 1);
      check($sformatf("%s_rdy_c%0d", tag, cyc), coeff_ready, exp_rdy);
      if (coeff_valid && coeff_ready) begin
        idx++;
        n_acc++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    coeff_valid = 1'b0;
    done_cyc = cyc;
    if (!done) check({tag, "_done_timeout"}, 0, 1);
  endtask

  // ---------------- test sequence ----------------
  int dc;
  int na;

  initial begin
    // Reset and idle.
    #12;
    check("rst_weights", weights, '0);
    check("rst_ready", coeff_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(); step();
    check("idle_busy", busy, 0);
    check("idle_weights", weights, '0);

    // Set A: valid held high, 24'hFFFFFF as the last coefficient.
    for (int k = 0; k < NT - 1; k++) vec[k] = DW'(k + 1);
    vec[NT-1] = 24'hFFFFFF;
    load(0, 1'b0, "A", dc, na);
    check("A_done_cyc", dc, 10);
    check("A_accepts", na, 8);
    check("A_busy_at_done", busy, 0);
    check("A_flat", weights, {24'hFFFFFF, 24'h000007, 24'h000006, 24'h000005,
                              24'h000004, 24'h000003, 24'h000002, 24'h000001});
    check_bank("A_bank");
    step();
    check("A_done_pulse", done, 0);
    check("A_weights_hold", weights, last_bank);

    // Set B: valid toggled 1,0,1,0; 8 accepts on cycles 1,3,...,15.
    vec = '{24'h800000, 24'h7FFFFF, 24'h123456, 24'hABCDEF,
            24'h000000, 24'hFEDCBA, 24'h0F0F0F, 24'hF0F0F0};
    load(1, 1'b0, "B", dc, na);
    check("B_done_cyc", dc, 17);
    check("B_accepts", na, 8);
    check_bank("B_bank");
    step();
    check("B_done_pulse", done, 0);

    // Abort together with the 5th valid: previous set must survive.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      coeff_valid = 1'b1;
      coeff = DW'(24'h111111 * (k + 1));
      step();
    end
    check("ab_ready_5", coeff_ready, 1);
    coeff = 24'h555555;
    abort = 1'b1;
    step();
    abort = 1'b0;
    coeff_valid = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_ready", coeff_ready, 0);
    check("ab_error", error, 1);
    check("ab_weights", weights, last_bank);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_idle_abort_state", state, 0);
    check("ab_error_sticky", error, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ab_start_clr_error", error, 0);
    check("ab_start_ready", coeff_ready, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab2_error", error, 1);
    check("ab2_weights", weights, last_bank);
    step();

    // Set D with start pulses in LOAD and COMMIT, then set E back-to-back.
    vec = '{24'h000010, 24'h000020, 24'h000030, 24'h000040,
            24'h000050, 24'h000060, 24'h000070, 24'h000080};
    load(0, 1'b1, "D", dc, na);
    check("D_done_cyc", dc, 10);
    check("D_accepts", na, 8);
    check("D_error_cleared", error, 0);
    check_bank("D_bank");
    vec = '{24'hA00001, 24'hA00002, 24'hA00003, 24'hA00004,
            24'hA00005, 24'hA00006, 24'hA00007, 24'hA00008};
    load(0, 1'b0, "E", dc, na);
    check("E_done_cyc", dc, 10);
    check_bank("E_bank");
    step();
    check("E_done_pulse", done, 0);
    check("E_busy", busy, 0);

    // Asynchronous reset after 3 accepts.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      coeff_valid = 1'b1;
      coeff = DW'(24'h0C0000 + k);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rr_weights", weights, '0);
    check("rr_busy", busy, 0);
    check("rr_ready", coeff_ready, 0);
    check("rr_error", error, 0);
    coeff_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("rr_no_done_c%0d", c), done, 0);
    end
    check("rr_idle", busy, 0);

`ifdef FIR_COEFF_READBACK_EN
    // Readback of tap 3 after loading 10..17.
    for (int k = 0; k < NT; k++) vec[k] = DW'(10 + k);
    load(0, 1'b0, "R", dc, na);
    check_bank("R_bank");
    rd_idx = 3;
    step();
    check("rd_tap3", rd_data, 13);
    rd_idx = 7;
    step();
    check("rd_tap7", rd_data, 17);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Writer side of the FIR weight interface. Accepts a stream of coefficients over a valid/ready handshake and stages them in a shadow bank. Commits them atomically to the active weight bank that drives every tap's weight input. The FIR datapath never sees a partially loaded coefficient set.

Parameters:
DATA_WIDTH, 24, width of one coefficient (two's complement, same format as tap weights)
NUM_TAPS, 8, number of coefficients per set (>= 2)

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request a new load; honoured only in IDLE
i_abort  input  1  cancel an in-progress load
iv_coeff  input  DATA_WIDTH  coefficient data
i_coeff_valid  input  1  iv_coeff is valid
o_coeff_ready  output  1  loader accepts a coefficient this cycle
ov_weights  output  NUM_TAPS*DATA_WIDTH  active bank, flattened; tap k at bits [k*DATA_WIDTH +: DATA_WIDTH]
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle pulse when the active bank has just been updated
o_error  output  1  sticky: the last load was aborted

Behaviour:
- Reset (asynchronous, i_rst_n=0): state IDLE, shadow and active banks all 0, index counter 0, o_done 0, o_error 0. o_coeff_ready and o_busy are 0 as a consequence of IDLE.
- States: IDLE, LOAD, COMMIT. Registered state. o_coeff_ready = (state==LOAD). o_busy = (state!=IDLE).
- IDLE:
  - i_start=1 -> LOAD; counter <= 0; o_error <= 0.
  - i_abort in IDLE is ignored.
- LOAD:
  - Transfer occurs when i_coeff_valid && o_coeff_ready. On a transfer, shadow[counter] <= iv_coeff and counter increments.
  - The first coefficient received goes to tap 0.
  - A transfer with counter==NUM_TAPS-1 moves the FSM to COMMIT. Ready drops the following cycle, so there are exactly NUM_TAPS accepts.
  - i_abort=1 -> IDLE and o_error <= 1. Abort wins over a simultaneous transfer: the coefficient is discarded. Active bank unchanged. Shadow contents are don't-care.
  - i_start in LOAD or COMMIT is ignored.
  - Valid low stalls indefinitely with no timeout. iv_coeff is ignored whenever no transfer occurs.
- COMMIT (exactly one cycle):
  - active bank <= shadow bank; o_done <= 1 for one cycle; -> IDLE.
  - i_abort is ignored in COMMIT; the commit always completes.
- Timing with valid held high: start sampled at edge 0.
  - Ready is high during cycles 1..NUM_TAPS and accepts on each.
  - COMMIT occupies cycle NUM_TAPS+1.
  - New ov_weights and o_done=1 appear in cycle NUM_TAPS+2, together with o_busy=0.
- Back-to-back: i_start asserted in the o_done cycle (state IDLE) is honoured.
- Arithmetic: none. Coefficients are stored bit-exact with no sign extension or truncation.
- Reset mid-load: everything returns to reset values, including the active bank (all zero weights).
- ov_weights changes only on the COMMIT edge or on reset.

Optional Feature:
Macro: FIR_COEFF_READBACK_EN.
- Defined:
  - Adds input iv_rd_idx (width $clog2(NUM_TAPS)) and output ov_rd_data (DATA_WIDTH).
  - ov_rd_data is registered: active[iv_rd_idx] one cycle after the index is sampled.
  - Index >= NUM_TAPS returns 0. Reset value is 0.
  - Readback reflects a new commit in the o_done cycle + 1.
- Not defined: neither port exists, and there is no readback logic.

Test Plan:
- Reset then idle -> ov_weights all 0, o_coeff_ready=0, o_busy=0, o_done=0, o_error=0.
- Start, then stream coefficients 1,2,...,8 with valid held high (24'hFFFFFF as 8th) -> 8 accepts in cycles 1..8; o_done high in cycle 10 only; tap0=1 ... tap7=24'hFFFFFF.
- Same load with valid toggled 1,0,1,0 -> stalls are honoured, no duplicates, correct order, commit after the 8th accept.
- Load 4 coefficients, then assert i_abort together with the 5th valid -> state returns to IDLE; o_error=1; ov_weights still holds the previous set; the next i_start clears o_error.
- i_start pulsed during LOAD and COMMIT -> ignored; exactly one o_done pulse; a start in the o_done cycle begins a new load.
- i_rst_n asserted after 3 accepts -> immediate asynchronous clear; ov_weights=0; no o_done. With FIR_COEFF_READBACK_EN: after loading 10..17, iv_rd_idx=3 -> ov_rd_data=13 one cycle later.
